// File: rtl/spi_cfg_uploader.sv
// SPI configuration uploader: streams {addr,data} words fetched from an external table to the sensor over 3-wire SPI.
// Defining SPI_CFG_VERIFY_EN adds a read-back frame after every write and compares spi_miso with the table value.
module spi_cfg_uploader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 12,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 5,
    parameter int CLK_DIV  = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic              clock_40,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  nrg,
    output logic [CNT_W-2:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
`ifdef SPI_CFG_VERIFY_EN
    input  logic              spi_miso,
    output logic              vfy_err,
    output logic [CNT_W-2:0]  vfy_idx,
`endif
    output logic              spi_clk,
    output logic              spi_en,
    output logic              spi_dat,
    output logic              busy,
    output logic [CNT_W-1:0]  reg_cnt,
    output logic              cfg_done
);

    localparam int WR_BITS = ADDR_W + DATA_W;
`ifdef SPI_CFG_VERIFY_EN
    localparam int SR_W = WR_BITS + 1;
    localparam logic [7:0] RD_LAST    = 8'(SR_W - 1);
    localparam logic [7:0] DATA_FIRST = 8'(ADDR_W + 1);
`else
    localparam int SR_W = WR_BITS;
`endif
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [7:0]       WR_LAST  = 8'(WR_BITS - 1);
    localparam logic [CNT_W-1:0] MAX_REGS = CNT_W'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_END, S_GAP, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_startD;
    logic [15:0]       r_div;
    logic [7:0]        r_bit;
    logic [7:0]        r_lastBit;
    logic [SR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_nTgt;
    logic [CNT_W-1:0]  r_regCnt;
    logic [CNT_W-2:0]  r_tblIdx;
    logic              r_spiClk;
    logic              r_spiEn;
    logic              r_spiDat;
    logic              r_busy;
    logic              r_cfgDone;

    logic [CNT_W-1:0]  w_nTgt;
    logic [SR_W-1:0]   w_wrWord;
    logic              w_divEnd;
    logic              w_gapEnd;
    logic              w_pairDone;

`ifdef SPI_CFG_VERIFY_EN
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_exp;
    logic              r_vfyErr;
    logic [CNT_W-2:0]  r_vfyIdx;

    assign w_wrWord   = {tbl_addr, tbl_data, 1'b0};
    assign w_pairDone = r_rd;
    assign vfy_err    = r_vfyErr;
    assign vfy_idx    = r_vfyIdx;
`else
    assign w_wrWord   = {tbl_addr, tbl_data};
    assign w_pairDone = 1'b1;
`endif

    assign w_nTgt   = (nrg == '0 || nrg > MAX_REGS) ? MAX_REGS : nrg;
    assign w_divEnd = (r_div == DIV_LAST);
    assign w_gapEnd = (r_div == GAP_LAST);

    assign tbl_idx  = r_tblIdx;
    assign spi_clk  = r_spiClk;
    assign spi_en   = r_spiEn;
    assign spi_dat  = r_spiDat;
    assign busy     = r_busy;
    assign reg_cnt  = r_regCnt;
    assign cfg_done = r_cfgDone;

    // start_d resets high so a start line held high through reset needs a fresh rising edge.
    always_ff @(posedge clock_40) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_startD  <= 1'b1;
            r_div     <= '0;
            r_bit     <= '0;
            r_lastBit <= WR_LAST;
            r_sr      <= '0;
            r_nTgt    <= '0;
            r_regCnt  <= '0;
            r_tblIdx  <= '0;
            r_spiClk  <= 1'b0;
            r_spiEn   <= 1'b1;
            r_spiDat  <= 1'b0;
            r_busy    <= 1'b0;
            r_cfgDone <= 1'b0;
`ifdef SPI_CFG_VERIFY_EN
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_exp     <= '0;
            r_vfyErr  <= 1'b0;
            r_vfyIdx  <= '0;
`endif
        end else begin
            r_startD <= start;
            r_div    <= r_div + 16'd1;
            if (!start && r_state != S_IDLE && r_state != S_DONE) begin
                r_state   <= S_IDLE;
                r_spiEn   <= 1'b1;
                r_spiClk  <= 1'b0;
                r_spiDat  <= 1'b0;
                r_busy    <= 1'b0;
                r_cfgDone <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !r_startD) begin
                            r_nTgt   <= w_nTgt;
                            r_tblIdx <= '0;
                            r_regCnt <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_FETCH1;
`ifdef SPI_CFG_VERIFY_EN
                            r_vfyErr <= 1'b0;
`endif
                        end
                    end
                    S_FETCH1: r_state <= S_FETCH2;
                    S_FETCH2: begin
                        r_sr      <= w_wrWord;
                        r_spiEn   <= 1'b0;
                        r_spiDat  <= tbl_addr[ADDR_W-1];
                        r_div     <= '0;
                        r_bit     <= '0;
                        r_lastBit <= WR_LAST;
                        r_state   <= S_SETUP;
`ifdef SPI_CFG_VERIFY_EN
                        r_rd      <= 1'b0;
                        r_addr    <= tbl_addr;
                        r_exp     <= tbl_data;
`endif
                    end
                    S_SETUP: begin
                        if (w_divEnd) begin
                            r_spiClk <= 1'b1;
                            r_div    <= '0;
                            r_state  <= S_SHIFT_HI;
                        end
                    end
                    S_SHIFT_HI: begin
`ifdef SPI_CFG_VERIFY_EN
                        if (r_rd && r_div == '0 && r_bit >= DATA_FIRST) begin
                            r_exp <= r_exp << 1;
                            if (spi_miso != r_exp[DATA_W-1] && !r_vfyErr) begin
                                r_vfyErr <= 1'b1;
                                r_vfyIdx <= r_tblIdx;
                            end
                        end
`endif
                        if (w_divEnd) begin
                            r_spiClk <= 1'b0;
                            r_sr     <= r_sr << 1;
                            r_spiDat <= r_sr[SR_W-2];
                            r_div    <= '0;
                            r_state  <= S_SHIFT_LO;
                        end
                    end
                    // The last bit also gets its full low phase before END, giving 2*CLK_DIV clocks per bit.
                    S_SHIFT_LO: begin
                        if (w_divEnd) begin
                            r_div <= '0;
                            if (r_bit == r_lastBit) begin
                                r_state <= S_END;
                            end else begin
                                r_bit    <= r_bit + 8'd1;
                                r_spiClk <= 1'b1;
                                r_state  <= S_SHIFT_HI;
                            end
                        end
                    end
                    S_END: begin
                        if (w_divEnd) begin
                            r_spiEn  <= 1'b1;
                            r_spiDat <= 1'b0;
                            r_div    <= '0;
                            r_state  <= S_GAP;
                            if (w_pairDone) begin
                                r_regCnt <= r_regCnt + CNT_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_gapEnd) begin
                            r_div <= '0;
`ifdef SPI_CFG_VERIFY_EN
                            if (!r_rd) begin
                                r_rd      <= 1'b1;
                                r_sr      <= {1'b1, r_addr, {DATA_W{1'b0}}};
                                r_spiEn   <= 1'b0;
                                r_spiDat  <= 1'b1;
                                r_bit     <= '0;
                                r_lastBit <= RD_LAST;
                                r_state   <= S_SETUP;
                            end else
`endif
                            if (r_regCnt == r_nTgt) begin
                                r_busy    <= 1'b0;
                                r_cfgDone <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                r_tblIdx <= r_tblIdx + (CNT_W-1)'(1);
                                r_state  <= S_FETCH1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (!start) begin
                            r_cfgDone <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_uploader.sv
// Bench for spi_cfg_uploader: closed-form waveform model of the default build checked every cycle,
// plus directed checks including a second instance with 24-bit frames and CLK_DIV=GAP_CYC=1.
module tb_spi_cfg_uploader;

    localparam int CD  = 2;
    localparam int NB  = 16;
    localparam int FL  = CD * (2 * NB + 2);
    localparam int PER = 2 + FL + 4;

    logic        clock_40 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  nrg;
    logic [3:0]  tbl_idx;
    logic [3:0]  tbl_addr;
    logic [11:0] tbl_data;
    logic        spi_clk, spi_en, spi_dat, busy, cfg_done;
    logic [4:0]  reg_cnt;

    logic        start2;
    logic [4:0]  nrg2;
    logic [3:0]  tbl_idx2;
    logic [7:0]  tbl_addr2;
    logic [15:0] tbl_data2;
    logic        spi_clk2, spi_en2, spi_dat2, busy2, cfg_done2;
    logic [4:0]  reg_cnt2;

    logic [15:0] mem  [16];
    logic [23:0] mem2 [16];

    int checks = 0;
    int failures = 0;

    always #5 clock_40 = ~clock_40;

    spi_cfg_uploader dut (
        .clock_40(clock_40), .rst_n(rst_n), .start(start), .nrg(nrg),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .spi_clk(spi_clk), .spi_en(spi_en), .spi_dat(spi_dat),
        .busy(busy), .reg_cnt(reg_cnt), .cfg_done(cfg_done)
    );

    spi_cfg_uploader #(
        .ADDR_W(8), .DATA_W(16), .NUM_REGS(16), .CNT_W(5), .CLK_DIV(1), .GAP_CYC(1)
    ) dut2 (
        .clock_40(clock_40), .rst_n(rst_n), .start(start2), .nrg(nrg2),
        .tbl_idx(tbl_idx2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
        .spi_clk(spi_clk2), .spi_en(spi_en2), .spi_dat(spi_dat2),
        .busy(busy2), .reg_cnt(reg_cnt2), .cfg_done(cfg_done2)
    );

    // Synchronous table: data appears one clock after the index.
    always @(posedge clock_40) begin
        {tbl_addr, tbl_data}   <= mem[tbl_idx];
        {tbl_addr2, tbl_data2} <= mem2[tbl_idx2];
    end

    logic [15:0] capWord;
    logic [15:0] frameQ[$];
    int          pulses = 0;
    int          enLow = 0;
    int          doneRises = 0;
    logic [23:0] cap2;
    int          pulses2 = 0;
    int          enLow2 = 0;
    int          viol2 = 0;
    logic        prevDat2 = 1'b0;

    always @(posedge spi_clk) begin
        capWord = {capWord[14:0], spi_dat};
        pulses++;
    end
    always @(negedge spi_en) capWord = '0;
    always @(posedge spi_en) frameQ.push_back(capWord);
    always @(posedge cfg_done) doneRises++;
    always @(posedge spi_clk2) begin
        cap2 = {cap2[22:0], spi_dat2};
        pulses2++;
    end

    always @(negedge clock_40) begin
        if (spi_en === 1'b0) enLow++;
        if (spi_en2 === 1'b0) enLow2++;
        if (spi_clk2 === 1'b1 && spi_dat2 !== prevDat2) viol2++;
        prevDat2 = spi_dat2;
    end

    // Model: mode 0 idle, 1 uploading (d = clocks since the start edge), 2 done.
    int mMode = 0, d = 0, n = 0, mRegCnt = 0, mIdx = 0;
    bit mStartD = 1'b1, mValid = 1'b0;

    function automatic int regsDone(input int dd, input int nn);
        int r;
        if (dd < 2 + FL) return 0;
        r = (dd - 2 - FL) / PER + 1;
        return (r > nn) ? nn : r;
    endfunction

    function automatic int idxAt(input int dd, input int nn);
        int k;
        k = dd / PER;
        return (k < nn) ? k : nn - 1;
    endfunction

    always @(posedge clock_40) begin
        bit prev;
        prev = mStartD;
        if (!rst_n) begin
            mMode = 0; mRegCnt = 0; mIdx = 0; mStartD = 1'b1; mValid = 1'b1;
        end else begin
            mStartD = start;
            case (mMode)
                0: if (start && !prev) begin
                    mMode = 1; d = 0;
                    n = (nrg == 0 || nrg > 16) ? 16 : int'(nrg);
                end
                1: if (!start) begin
                    mRegCnt = regsDone(d, n); mIdx = idxAt(d, n); mMode = 0;
                end else begin
                    d++;
                    if (d >= PER * n) mMode = 2;
                end
                default: if (!start) begin
                    mMode = 0; mRegCnt = n; mIdx = n - 1;
                end
            endcase
        end
    end

    always @(negedge clock_40) begin
        logic eEn, eClk, eDat, eBusy, eDone;
        logic [4:0] eReg;
        logic [3:0] eIdx;
        int o, f, j;
        if (mValid) begin
            eEn = 1'b1; eClk = 1'b0; eDat = 1'b0; eBusy = 1'b0; eDone = 1'b0;
            eReg = 5'(mRegCnt); eIdx = 4'(mIdx);
            if (mMode == 1) begin
                eBusy = 1'b1;
                eReg = 5'(regsDone(d, n));
                eIdx = 4'(idxAt(d, n));
                if (d >= 2) begin
                    o = (d - 2) % PER;
                    f = (d - 2) / PER;
                    if (o < FL) begin
                        eEn = 1'b0;
                        eClk = ((o / CD) % 2 == 1) && (o < CD * (2 * NB + 1));
                        j = o / (2 * CD);
                        eDat = (j < NB) ? mem[f][NB-1-j] : 1'b0;
                    end
                end
            end else if (mMode == 2) begin
                eDone = 1'b1; eReg = 5'(n); eIdx = 4'(n - 1);
            end
            checks++;
            if ({spi_en, spi_clk, spi_dat, busy, cfg_done, reg_cnt, tbl_idx} !==
                {eEn, eClk, eDat, eBusy, eDone, eReg, eIdx}) begin
                failures++;
                $display("[TB] FAIL cycle_model t=%0t actual(en,clk,dat,busy,done,cnt,idx)=%b%b%b%b%b,%0d,%0d required=%b%b%b%b%b,%0d,%0d",
                         $time, spi_en, spi_clk, spi_dat, busy, cfg_done, reg_cnt, tbl_idx,
                         eEn, eClk, eDat, eBusy, eDone, eReg, eIdx);
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic [4:0] nn);
        @(negedge clock_40);
        start = s;
        nrg = nn;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic waitDone(input string name, input logic which, input int req);
        int cnt;
        cnt = 0;
        while (((which == 1'b0) ? cfg_done : cfg_done2) !== 1'b1 && cnt < 5000) begin
            @(negedge clock_40);
            cnt++;
        end
        checkOutput(name, cnt, req);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; nrg = '0; start2 = 1'b0; nrg2 = 5'd1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            mem2[i] = '0;
        end
        mem[0] = 16'h0029;
        mem2[0] = 24'hA53C96;
        repeat (3) @(negedge clock_40);
        checkOutput("rst_spi_en", spi_en, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_reg_cnt", reg_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock_40);

        $display("[TB] single register upload");
        pulses = 0; enLow = 0;
        applyStimulus(1, 5'd1);
        waitDone("t1_done_latency", 1'b0, 75);
        checkOutput("t1_pulses", pulses, 16);
        checkOutput("t1_word", capWord, 16'h0029);
        checkOutput("t1_en_low", enLow, 68);
        checkOutput("t1_reg_cnt", reg_cnt, 1);
        applyStimulus(0, 5'd1);
        repeat (2) @(negedge clock_40);
        checkOutput("t1_done_cleared", cfg_done, 0);
        checkOutput("t1_reg_cnt_hold", reg_cnt, 1);

        $display("[TB] full table upload");
        for (int i = 0; i < 16; i++) mem[i] = {4'(i), 12'h0A0 + 12'(i)};
        frameQ.delete(); doneRises = 0;
        applyStimulus(1, 5'd16);
        waitDone("t2_done_latency", 1'b0, 1185);
        checkOutput("t2_frames", frameQ.size(), 16);
        for (int i = 0; i < 16 && i < frameQ.size(); i++)
            checkOutput($sformatf("t2_frame%0d", i), frameQ[i], {4'(i), 12'h0A0 + 12'(i)});
        checkOutput("t2_reg_cnt", reg_cnt, 16);
        repeat (3) @(negedge clock_40);
        checkOutput("t2_done_once", doneRises, 1);
        applyStimulus(0, 5'd0);

        $display("[TB] nrg clamping");
        frameQ.delete();
        applyStimulus(1, 5'd0);
        waitDone("t3_zero_latency", 1'b0, 1185);
        checkOutput("t3_zero_frames", frameQ.size(), 16);
        applyStimulus(0, 5'd0);
        frameQ.delete();
        applyStimulus(1, 5'd20);
        waitDone("t3_twenty_latency", 1'b0, 1185);
        checkOutput("t3_twenty_frames", frameQ.size(), 16);
        checkOutput("t3_twenty_reg_cnt", reg_cnt, 16);
        applyStimulus(0, 5'd0);

        $display("[TB] abort mid frame");
        applyStimulus(1, 5'd16);
        repeat (184) @(negedge clock_40);
        start = 1'b0;
        @(negedge clock_40);
        checkOutput("t4_spi_en", spi_en, 1);
        checkOutput("t4_spi_clk", spi_clk, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_reg_cnt", reg_cnt, 2);
        checkOutput("t4_cfg_done", cfg_done, 0);
        checkOutput("t4_idx_before", tbl_idx, 2);
        applyStimulus(1, 5'd16);
        repeat (2) @(negedge clock_40);
        checkOutput("t4_restart_idx", tbl_idx, 0);
        checkOutput("t4_restart_busy", busy, 1);

        $display("[TB] reset mid shift");
        repeat (20) @(negedge clock_40);
        rst_n = 1'b0;
        @(negedge clock_40);
        rst_n = 1'b1;
        checkOutput("t5_spi_en", spi_en, 1);
        checkOutput("t5_spi_clk", spi_clk, 0);
        checkOutput("t5_spi_dat", spi_dat, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_tbl_idx", tbl_idx, 0);
        pulses = 0;
        repeat (100) @(negedge clock_40);
        checkOutput("t5_no_pulses", pulses, 0);
        checkOutput("t5_still_idle", busy, 0);
        applyStimulus(0, 5'd1);
        frameQ.delete();
        applyStimulus(1, 5'd1);
        waitDone("t5_restart_latency", 1'b0, 75);
        checkOutput("t5_restart_frames", frameQ.size(), 1);
        if (frameQ.size() > 0) checkOutput("t5_restart_word", frameQ[0], 16'h00A0);
        applyStimulus(0, 5'd0);

        $display("[TB] 24-bit frames, CLK_DIV=1, GAP_CYC=1");
        pulses2 = 0; enLow2 = 0; viol2 = 0;
        @(negedge clock_40);
        start2 = 1'b1;
        waitDone("t6_done_latency", 1'b1, 54);
        checkOutput("t6_pulses", pulses2, 24);
        checkOutput("t6_word", cap2, 24'hA53C96);
        checkOutput("t6_en_low", enLow2, 50);
        checkOutput("t6_dat_stable", viol2, 0);
        checkOutput("t6_reg_cnt", reg_cnt2, 1);
        @(negedge clock_40);
        start2 = 1'b0;
        repeat (3) @(negedge clock_40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
